fetch_ctrl: RTL and testbench

Fetch-stage sequencer for the five-stage MIPS pipeline. It owns the fetch PC register, issues instruction-memory requests over a valid/ready handshake, and absorbs hazard stalls and variable memory latency. It loads the next-PC value computed by the next-PC unit, and it is the F/D pipeline register. Downstream, D-stage logic sees only `fd_valid`, `fd_pc`, `fd_instr` and `fd_exc`.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/pc_legal_chk.sv | 14 +
 rtl/fetch_ctrl.sv | 131 +++++++++++++
 tb/tb_fetch_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: state encoding, address-map
// defaults, the NOP word and the address-legality helper.
package fetch_pkg;

  typedef logic [1:0] fstate_t;

  // REQ: request in flight for f_pc.
  // HOLD: word returned and buffered while F is stalled.
  // BAD: f_pc is illegal, so no request is issued.
  localparam fstate_t ST_REQ  = 2'd0;
  localparam fstate_t ST_HOLD = 2'd1;
  localparam fstate_t ST_BAD  = 2'd2;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT_DEF = 32'h0000_6FFC;
  localparam logic [31:0] NOP          = 32'h0000_0000;

  // A fetch address is legal when word aligned and inside [base, limit].
  function automatic logic pc_is_legal(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] limit);
    return (addr[1:0] == 2'b00) && (addr >= base) && (addr <= limit);
  endfunction

endpackage

// File: rtl/pc_legal_chk.sv
// Combinational instruction-address legality check.
module pc_legal_chk
  import fetch_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEF
) (
  input  logic [31:0] addr_i,
  output logic        legal_o
);

  assign legal_o = pc_is_legal(addr_i, IM_BASE, IM_LIMIT);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, issues instruction-memory
// requests, absorbs stalls and memory wait states, and is the F/D register.
//
// Handshake: imem_req is the request valid and imem_addr the request
// payload; both stay stable until a cycle with imem_req & imem_ready, in
// which imem_rdata carries the word. imem_ready outside REQ is ignored.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_LIMIT = IM_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_i,
  input  logic [31:0] npc_i,
  output logic [31:0] f_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        fd_valid,
  output logic [31:0] fd_pc,
  output logic [31:0] fd_instr,
  output logic        fd_exc
);

  // An illegal reset PC starts directly in BAD.
  localparam fstate_t RESET_ST =
    pc_is_legal(RESET_PC, IM_BASE, IM_LIMIT) ? ST_REQ : ST_BAD;

  fstate_t     state_q, state_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] buf_q, buf_d;
  logic        fd_valid_q, fd_valid_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic [31:0] fd_instr_q, fd_instr_d;
  logic        fd_exc_q, fd_exc_d;

  logic        f_legal;
  logic        npc_legal;
  logic        have;
  logic        advance;
  logic [31:0] word;

  pc_legal_chk #(.IM_BASE(IM_BASE), .IM_LIMIT(IM_LIMIT)) u_chk_fpc (
    .addr_i  (f_pc_q),
    .legal_o (f_legal)
  );

  pc_legal_chk #(.IM_BASE(IM_BASE), .IM_LIMIT(IM_LIMIT)) u_chk_npc (
    .addr_i  (npc_i),
    .legal_o (npc_legal)
  );

  // Request only in REQ; gating with reset_n drops it the moment reset asserts.
  assign imem_req  = reset_n & (state_q == ST_REQ) & f_legal;
  assign imem_addr = f_pc_q;
  assign f_pc      = f_pc_q;
  assign fd_valid  = fd_valid_q;
  assign fd_pc     = fd_pc_q;
  assign fd_instr  = fd_instr_q;
  assign fd_exc    = fd_exc_q;

  // Next-state logic for the FSM, PC register, buffer and F/D register.
  always_comb begin
    state_d    = state_q;
    f_pc_d     = f_pc_q;
    buf_d      = buf_q;
    fd_valid_d = fd_valid_q;
    fd_pc_d    = fd_pc_q;
    fd_instr_d = fd_instr_q;
    fd_exc_d   = fd_exc_q;
    have       = 1'b0;
    word       = NOP;

    case (state_q)
      ST_REQ:  begin have = imem_ready; word = imem_rdata; end
      ST_HOLD: begin have = 1'b1;       word = buf_q;      end
      ST_BAD:  begin have = 1'b1;       word = NOP;        end
      default: begin have = 1'b0;       word = NOP;        end
    endcase

    advance = have & ~stall_i;

    if (advance) begin
      fd_pc_d    = f_pc_q;
      fd_instr_d = word;
      fd_valid_d = 1'b1;
      fd_exc_d   = (state_q == ST_BAD);
      f_pc_d     = npc_i;
      state_d    = npc_legal ? ST_REQ : ST_BAD;
    end else if ((state_q == ST_REQ) && imem_ready && stall_i) begin
      // Word returned during a stall: keep it so it is never dropped.
      buf_d   = imem_rdata;
      state_d = ST_HOLD;
    end else if ((state_q == ST_REQ) && !imem_ready && !stall_i) begin
      // Memory wait cycle: one bubble into D, fd_pc left as is.
      fd_valid_d = 1'b0;
      fd_instr_d = NOP;
      fd_exc_d   = 1'b0;
    end else if ((state_q != ST_REQ) && (state_q != ST_HOLD) &&
                 (state_q != ST_BAD)) begin
      // Unused encoding: re-enter the state implied by the current PC.
      state_d = f_legal ? ST_REQ : ST_BAD;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_ST;
      f_pc_q     <= RESET_PC;
      buf_q      <= NOP;
      fd_valid_q <= 1'b0;
      fd_pc_q    <= 32'h0;
      fd_instr_q <= NOP;
      fd_exc_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      f_pc_q     <= f_pc_d;
      buf_q      <= buf_d;
      fd_valid_q <= fd_valid_d;
      fd_pc_q    <= fd_pc_d;
      fd_instr_q <= fd_instr_d;
      fd_exc_q   <= fd_exc_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed per-cycle vectors push expected
// request and F/D values into queues; a negedge monitor pops and compares.
module tb_fetch_ctrl;

  logic        clk;
  logic        reset_n;
  logic        stall_i;
  logic [31:0] npc_i;
  logic [31:0] f_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        fd_valid;
  logic [31:0] fd_pc;
  logic [31:0] fd_instr;
  logic        fd_exc;

  int n_chk;
  int n_pass;

  // {req, addr} expected during the current cycle
  logic [32:0] imem_q[$];
  // {valid, exc, pc, instr} expected after the previous clock edge
  logic [65:0] fd_q[$];

  fetch_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .stall_i    (stall_i),
    .npc_i      (npc_i),
    .f_pc       (f_pc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .fd_valid   (fd_valid),
    .fd_pc      (fd_pc),
    .fd_instr   (fd_instr),
    .fd_exc     (fd_exc)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [32:0] ie;
    logic [65:0] fe;
    if (imem_q.size() > 0) begin
      ie = imem_q.pop_front();
      chk("imem_req",  {31'h0, imem_req}, {31'h0, ie[32]});
      chk("imem_addr", imem_addr, ie[31:0]);
      chk("f_pc",      f_pc,      ie[31:0]);
    end
    if (fd_q.size() > 0) begin
      fe = fd_q.pop_front();
      chk("fd_valid", {31'h0, fd_valid}, {31'h0, fe[65]});
      chk("fd_exc",   {31'h0, fd_exc},   {31'h0, fe[64]});
      chk("fd_pc",    fd_pc,    fe[63:32]);
      chk("fd_instr", fd_instr, fe[31:0]);
    end
  end

  // Driver: one clock cycle of inputs plus its expected responses.
  task automatic cyc(input logic st, input logic rdy, input logic [31:0] rd,
                     input logic [31:0] npc, input logic e_req,
                     input logic [31:0] e_addr, input logic v, input logic e,
                     input logic [31:0] pc, input logic [31:0] ins);
    stall_i    = st;
    imem_ready = rdy;
    imem_rdata = rd;
    npc_i      = npc;
    imem_q.push_back({e_req, e_addr});
    @(posedge clk);
    #1;
    fd_q.push_back({v, e, pc, ins});
  endtask

  initial begin
    n_chk      = 0;
    n_pass     = 0;
    reset_n    = 1'b1;
    stall_i    = 1'b0;
    imem_ready = 1'b1;
    imem_rdata = 32'h0;
    npc_i      = 32'h0;
    #1 reset_n = 1'b0;
    #3;
    chk("rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("rst_f_pc",     f_pc,              32'h0000_3000);
    chk("rst_fd_valid", {31'h0, fd_valid}, 32'h0);
    chk("rst_fd_pc",    fd_pc,             32'h0);
    chk("rst_fd_instr", fd_instr,          32'h0);
    chk("rst_fd_exc",   {31'h0, fd_exc},   32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;

    //   st  rdy rdata         npc            req addr           v  e  fd_pc          fd_instr
    // zero-wait streaming
    cyc(0, 1, 32'h1000_3000, 32'h0000_3004, 1, 32'h0000_3000, 1, 0, 32'h0000_3000, 32'h1000_3000);
    cyc(0, 1, 32'h1000_3004, 32'h0000_3008, 1, 32'h0000_3004, 1, 0, 32'h0000_3004, 32'h1000_3004);
    cyc(0, 1, 32'h1000_3008, 32'h0000_300C, 1, 32'h0000_3008, 1, 0, 32'h0000_3008, 32'h1000_3008);
    // redirect to 3100 at the advance of 300C
    cyc(0, 1, 32'h1000_300C, 32'h0000_3100, 1, 32'h0000_300C, 1, 0, 32'h0000_300C, 32'h1000_300C);
    // two wait cycles on 3100: two bubbles, address stable
    cyc(0, 0, 32'hDEAD_BEEF, 32'h0000_3104, 1, 32'h0000_3100, 0, 0, 32'h0000_300C, 32'h0);
    cyc(0, 0, 32'hDEAD_BEEF, 32'h0000_3104, 1, 32'h0000_3100, 0, 0, 32'h0000_300C, 32'h0);
    cyc(0, 1, 32'h1000_3100, 32'h0000_3104, 1, 32'h0000_3100, 1, 0, 32'h0000_3100, 32'h1000_3100);
    // stall together with data return, held 3 cycles; late ready ignored
    cyc(1, 1, 32'h2408_0001, 32'h0000_3108, 1, 32'h0000_3104, 1, 0, 32'h0000_3100, 32'h1000_3100);
    cyc(1, 1, 32'hDEAD_BEEF, 32'h0000_3108, 0, 32'h0000_3104, 1, 0, 32'h0000_3100, 32'h1000_3100);
    cyc(1, 0, 32'hDEAD_BEEF, 32'h0000_3108, 0, 32'h0000_3104, 1, 0, 32'h0000_3100, 32'h1000_3100);
    cyc(0, 1, 32'hDEAD_BEEF, 32'h0000_3108, 0, 32'h0000_3104, 1, 0, 32'h0000_3104, 32'h2408_0001);
    // misaligned next PC, then out-of-range next PC (stalled once in BAD)
    cyc(0, 1, 32'h1000_3108, 32'h0000_3002, 1, 32'h0000_3108, 1, 0, 32'h0000_3108, 32'h1000_3108);
    cyc(0, 1, 32'hDEAD_BEEF, 32'h0000_7000, 0, 32'h0000_3002, 1, 1, 32'h0000_3002, 32'h0);
    cyc(1, 1, 32'hDEAD_BEEF, 32'h0000_3200, 0, 32'h0000_7000, 1, 1, 32'h0000_3002, 32'h0);
    cyc(0, 1, 32'hDEAD_BEEF, 32'h0000_3200, 0, 32'h0000_7000, 1, 1, 32'h0000_7000, 32'h0);
    // recovery to a legal PC, then a waiting request
    cyc(0, 1, 32'h1000_3200, 32'h0000_3204, 1, 32'h0000_3200, 1, 0, 32'h0000_3200, 32'h1000_3200);
    cyc(0, 0, 32'hDEAD_BEEF, 32'h0000_3208, 1, 32'h0000_3204, 0, 0, 32'h0000_3200, 32'h0);

    // reset asserted while the request for 3204 is still waiting
    imem_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_req_before", {31'h0, imem_req}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_imem_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_f_pc",     f_pc,              32'h0000_3000);
    chk("mid_rst_fd_valid", {31'h0, fd_valid}, 32'h0);
    chk("mid_rst_fd_pc",    fd_pc,             32'h0);
    chk("mid_rst_fd_instr", fd_instr,          32'h0);
    chk("mid_rst_fd_exc",   {31'h0, fd_exc},   32'h0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    cyc(0, 1, 32'h1000_3000, 32'h0000_3004, 1, 32'h0000_3000, 1, 0, 32'h0000_3000, 32'h1000_3000);
    @(negedge clk);
    #1;
    chk("imem_q_drained", imem_q.size(), 32'h0);
    chk("fd_q_drained",   fd_q.size(),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
